// File: rtl/rca_sequencer.sv
// Bit-serial-by-nibble adder/subtractor: one shared 4-bit ripple-carry adder
// is reused across NIBBLES cycles, LSB nibble first.

module rca (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign sum   = total[3:0];
   assign cout  = total[4];
endmodule

module rca_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   carry_out,
   output logic                   overflow
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     result_q;
   logic [IDX_W-1:0] idx_q;
   logic             sub_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             carry_out_q;
   logic             overflow_q;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       rca_sum;
   logic             rca_cout;
   logic             ovf_d;

   assign nib_a = a_q[4*int'(idx_q) +: 4];
   assign nib_b = b_q[4*int'(idx_q) +: 4];

   rca u_rca (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   // Signed overflow: operands agree in sign but the final sum bit does not.
   assign ovf_d = (a_q[W-1] == b_q[W-1]) && (rca_sum[3] != a_q[W-1]);

   // NOTE: reset is sampled on the clock edge only, so rst_n sits in the
   // body of the clocked block rather than in its sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: state uses non-blocking assignments so every register
         // updates from pre-edge values, independent of statement order.
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         idx_q       <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  sub_q   <= sub;
                  carry_q <= sub;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end

            RUN: begin
               result_q[4*int'(idx_q) +: 4] <= rca_sum;
               carry_q <= rca_cout;
               idx_q   <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  carry_out_q <= rca_cout;
                  overflow_q  <= ovf_d;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // The first nibble of every operation must see the subtract flag as cin.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == RUN && idx_q == '0)
         assert (carry_q == sub_q);
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_rca_sequencer.sv
// Scoreboard bench for rca_sequencer: stimulus queues expected results with
// their due cycle, a negedge monitor pops and compares on every done pulse.

module tb_rca_sequencer;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry_out;
   logic        overflow;

   typedef struct {
      logic [15:0] res;
      logic        c;
      logic        o;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_pass;

   rca_sequencer #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("done_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result",    32'(result),    32'(e.res));
            check("carry_out", 32'(carry_out), 32'(e.c));
            check("overflow",  32'(overflow),  32'(e.o));
            check("done_cycle", cyc,           e.due);
         end
      end
   end

   // Issue one operation from an idle/done DUT and watch busy through it.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] er, input logic ec, input logic eo);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; sub = s;
      @(posedge clk); #1;
      e.res = er; e.c = ec; e.o = eo; e.due = cyc + 4;
      sb.push_back(e);
      start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~s;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("busy_run", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      exp_t e;
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_result",    32'(result),    32'h0000);
      check("rst_carry_out", 32'(carry_out), 32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      rst_n = 1'b1;

      // Directed arithmetic vectors
      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Back-to-back with start held high throughout
      @(negedge clk);
      start = 1'b1; op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0;
      @(posedge clk); #1;
      e.res = 16'h0002; e.c = 1'b0; e.o = 1'b0; e.due = cyc + 4;
      sb.push_back(e);
      op_a = 16'h0002; op_b = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b2b_busy_run1", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("b2b_busy_done1", 32'(busy), 32'd0);
      @(posedge clk); #1;
      e.res = 16'h0004; e.c = 1'b0; e.o = 1'b0; e.due = cyc + 4;
      sb.push_back(e);
      op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_run2", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      check("b2b_busy_run2_last", 32'(busy), 32'd1);
      @(negedge clk);
      check("b2b_busy_done2", 32'(busy), 32'd0);

      // Abort: reset lands on the third edge of an operation, start held high
      @(negedge clk);
      start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1;
      @(negedge clk);
      check("abort_busy",   32'(busy),   32'd0);
      check("abort_done",   32'(done),   32'd0);
      check("abort_result", 32'(result), 32'h0000);
      rst_n = 1'b1; start = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_idle_busy", 32'(busy), 32'd0);
      run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
